// File: rtl/sram_imag_arbiter_if.sv
// Requester, SRAM and error-flag bundle for the imaginary-part SRAM arbiter.
// slave = arbiter side, master = DMA/compute engines plus the SRAM macro.
interface sram_imag_arbiter_if;
    logic        dma_req;
    logic [3:0]  dma_wstrb;
    logic [15:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    logic        cmp_req;
    logic [3:0]  cmp_wstrb_a, cmp_wstrb_b;
    logic [15:0] cmp_addr_a, cmp_addr_b;
    logic [31:0] cmp_wdata_a, cmp_wdata_b;
    logic        cmp_gnt;
    logic        cmp_rvalid;
    logic [31:0] cmp_rdata_a, cmp_rdata_b;

    logic [3:0]  wea0, wea1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [31:0] rdata0, rdata1;

    logic        err_clr;
    logic        oob_err;

    modport slave (
        input  dma_req, dma_wstrb, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        input  cmp_req, cmp_wstrb_a, cmp_wstrb_b, cmp_addr_a, cmp_addr_b,
        input  cmp_wdata_a, cmp_wdata_b,
        output cmp_gnt, cmp_rvalid, cmp_rdata_a, cmp_rdata_b,
        output wea0, wea1, addr0, addr1, wdata0, wdata1,
        input  rdata0, rdata1,
        input  err_clr,
        output oob_err
    );

    modport master (
        output dma_req, dma_wstrb, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        output cmp_req, cmp_wstrb_a, cmp_wstrb_b, cmp_addr_a, cmp_addr_b,
        output cmp_wdata_a, cmp_wdata_b,
        input  cmp_gnt, cmp_rvalid, cmp_rdata_a, cmp_rdata_b,
        input  wea0, wea1, addr0, addr1, wdata0, wdata1,
        output rdata0, rdata1,
        output err_clr,
        input  oob_err
    );
endinterface

// File: rtl/sram_imag_arbiter.sv
// Burst-based DMA/compute arbiter for the dual-port imag SRAM; optional SRAM_ARB_OOB_CHK_EN range check.
// Latency: grant and SRAM drive combinational from state+req, read data 1 cycle after grant.
// Backpressure: req held until gnt; owner keeps the SRAM up to MAX_BURST beats while the other waits.
module sram_imag_arbiter #(
    parameter int DEPTH     = 480,
    parameter int MAX_BURST = 16
) (
    input logic                clk,
    input logic                rst_n,
    sram_imag_arbiter_if.slave bus
);
`ifdef SRAM_ARB_OOB_CHK_EN
    localparam bit OOB_EN = 1'b1;
`else
    localparam bit OOB_EN = 1'b0;
`endif
    localparam int              BW         = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX  = BW'(MAX_BURST);
    localparam logic [BW-1:0]   BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [15:0]     ADDR_LIM   = 16'(DEPTH);

    typedef enum logic [1:0] {IDLE, DMA, CMP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          dma_gnt, cmp_gnt;

    logic [3:0]    strb0, strb1;
    logic [15:0]   a0, a1;
    logic [31:0]   wd0, wd1;
    logic          act0, act1, rd0, rd1, oob0, oob1, coll;

    logic          dma_tag_q, dma_tag_d;
    logic [1:0]    cmp_tag_q, cmp_tag_d;
    logic [1:0]    oob_tag_q, oob_tag_d;
    logic [31:0]   dma_rdata_q, dma_rdata_d;
    logic [31:0]   cmp_rdata_a_q, cmp_rdata_a_d;
    logic [31:0]   cmp_rdata_b_q, cmp_rdata_b_d;
    logic [31:0]   fwd0, fwd1;
    logic          oob_err_q, oob_err_d;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        dma_gnt = 1'b0;
        cmp_gnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmp_req)      state_d = CMP;
                else if (bus.dma_req) state_d = DMA;
            end
            DMA: begin
                dma_gnt = bus.dma_req;
                if (!bus.dma_req) begin
                    state_d = bus.cmp_req ? CMP : IDLE;
                end else begin
                    if (bcnt_q != BURST_MAX) bcnt_d = bcnt_q + BW'(1);
                    if (bcnt_q >= BURST_LAST && bus.cmp_req) state_d = CMP;
                end
            end
            CMP: begin
                cmp_gnt = bus.cmp_req;
                if (!bus.cmp_req) begin
                    state_d = bus.dma_req ? DMA : IDLE;
                end else begin
                    if (bcnt_q != BURST_MAX) bcnt_d = bcnt_q + BW'(1);
                    if (bcnt_q >= BURST_LAST && bus.dma_req) state_d = DMA;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) bcnt_d = '0;
    end

    always_comb begin
        act0  = 1'b0;
        act1  = 1'b0;
        strb0 = 4'h0;
        strb1 = 4'h0;
        a0    = 16'h0;
        a1    = 16'h0;
        wd0   = 32'h0;
        wd1   = 32'h0;
        if (dma_gnt) begin
            act0  = 1'b1;
            strb0 = bus.dma_wstrb;
            a0    = bus.dma_addr;
            wd0   = bus.dma_wdata;
        end else if (cmp_gnt) begin
            act0  = 1'b1;
            act1  = 1'b1;
            strb0 = bus.cmp_wstrb_a;
            strb1 = bus.cmp_wstrb_b;
            a0    = bus.cmp_addr_a;
            a1    = bus.cmp_addr_b;
            wd0   = bus.cmp_wdata_a;
            wd1   = bus.cmp_wdata_b;
        end
        // Same-word pair write: port 0 keeps its write, port 1 is suppressed.
        coll = act1 && (a0 == a1) && (|strb0) && (|strb1);
        oob0 = OOB_EN && act0 && (a0 >= ADDR_LIM);
        oob1 = OOB_EN && act1 && (a1 >= ADDR_LIM);
        // Read-ness comes from the requested strobes, not the masked enables.
        rd0  = act0 && (strb0 == 4'h0);
        rd1  = act1 && (strb1 == 4'h0);

        bus.wea0   = oob0 ? 4'h0 : strb0;
        bus.addr0  = oob0 ? 16'h0 : a0;
        bus.wdata0 = wd0;
        bus.wea1   = (oob1 || coll) ? 4'h0 : strb1;
        bus.addr1  = oob1 ? 16'h0 : a1;
        bus.wdata1 = wd1;
    end

    always_comb begin
        dma_tag_d     = dma_gnt && rd0;
        cmp_tag_d     = {cmp_gnt && rd1, cmp_gnt && rd0};
        oob_tag_d     = {oob1, oob0};
        fwd0          = oob_tag_q[0] ? 32'h0 : bus.rdata0;
        fwd1          = oob_tag_q[1] ? 32'h0 : bus.rdata1;
        dma_rdata_d   = dma_tag_q    ? fwd0 : dma_rdata_q;
        cmp_rdata_a_d = cmp_tag_q[0] ? fwd0 : cmp_rdata_a_q;
        cmp_rdata_b_d = cmp_tag_q[1] ? fwd1 : cmp_rdata_b_q;
        // A fresh error outranks a clear in the same cycle.
        oob_err_d     = OOB_EN && (oob0 || oob1 || (oob_err_q && !bus.err_clr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bcnt_q        <= '0;
            dma_tag_q     <= 1'b0;
            cmp_tag_q     <= 2'b00;
            oob_tag_q     <= 2'b00;
            dma_rdata_q   <= 32'h0;
            cmp_rdata_a_q <= 32'h0;
            cmp_rdata_b_q <= 32'h0;
            oob_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            dma_tag_q     <= dma_tag_d;
            cmp_tag_q     <= cmp_tag_d;
            oob_tag_q     <= oob_tag_d;
            dma_rdata_q   <= dma_rdata_d;
            cmp_rdata_a_q <= cmp_rdata_a_d;
            cmp_rdata_b_q <= cmp_rdata_b_d;
            oob_err_q     <= oob_err_d;
        end
    end

    assign bus.dma_gnt     = dma_gnt;
    assign bus.cmp_gnt     = cmp_gnt;
    assign bus.dma_rvalid  = dma_tag_q;
    assign bus.cmp_rvalid  = |cmp_tag_q;
    assign bus.dma_rdata   = dma_rdata_d;
    assign bus.cmp_rdata_a = cmp_rdata_a_d;
    assign bus.cmp_rdata_b = cmp_rdata_b_d;
    assign bus.oob_err     = oob_err_q;
endmodule

// File: tb/tb_sram_imag_arbiter.sv
// Directed bench for sram_imag_arbiter with a behavioural dual-port SRAM.
// Per-cycle vector table plus hand sequences for burst handover, range check and reset.
module tb_sram_imag_arbiter;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    sram_imag_arbiter_if bus_if ();

    sram_imag_arbiter #(.DEPTH(480), .MAX_BURST(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus_if.wea1[b]) mem[bus_if.addr1[8:0]][8*b +: 8] <= bus_if.wdata1[8*b +: 8];
            if (bus_if.wea0[b]) mem[bus_if.addr0[8:0]][8*b +: 8] <= bus_if.wdata0[8*b +: 8];
        end
        bus_if.rdata0 <= mem[bus_if.addr0[8:0]];
        bus_if.rdata1 <= mem[bus_if.addr1[8:0]];
    end

    typedef struct packed {
        logic        dreq;
        logic [3:0]  dws;
        logic [15:0] dad;
        logic [31:0] dwd;
        logic        creq;
        logic [3:0]  cwa, cwb;
        logic [15:0] caa, cab;
        logic [31:0] cda, cdb;
        logic        e_dg, e_cg;
        logic [3:0]  e_we0, e_we1;
        logic [15:0] e_a0, e_a1;
        logic [31:0] e_wd0, e_wd1;
        logic        e_drv, e_crv;
        logic [31:0] e_drd, e_crda, e_crdb;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic set_d(input logic r, input logic [3:0] ws, input logic [15:0] a, input logic [31:0] d);
        bus_if.dma_req   = r;
        bus_if.dma_wstrb = ws;
        bus_if.dma_addr  = a;
        bus_if.dma_wdata = d;
    endtask

    task automatic set_c(input logic r, input logic [3:0] wa, input logic [3:0] wb,
                         input logic [15:0] aa, input logic [15:0] ab,
                         input logic [31:0] da, input logic [31:0] db);
        bus_if.cmp_req     = r;
        bus_if.cmp_wstrb_a = wa;
        bus_if.cmp_wstrb_b = wb;
        bus_if.cmp_addr_a  = aa;
        bus_if.cmp_addr_b  = ab;
        bus_if.cmp_wdata_a = da;
        bus_if.cmp_wdata_b = db;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    bit prev_dg, prev_cg, exp_dg, exp_cg;

    initial begin
        vec[0]  = '{1'b1,4'hF,16'd5,32'hDEADBEEF, 1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0,
                    1'b0,1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,32'h0};
        vec[1]  = '{1'b1,4'hF,16'd5,32'hDEADBEEF, 1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0,
                    1'b1,1'b0,4'hF,4'h0,16'd5,16'd0,32'hDEADBEEF,32'h0, 1'b0,1'b0,32'h0,32'h0,32'h0};
        vec[2]  = '{1'b1,4'h0,16'd5,32'h0, 1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0,
                    1'b1,1'b0,4'h0,4'h0,16'd5,16'd0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,32'h0};
        vec[3]  = '{1'b0,4'h0,16'd0,32'h0, 1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0,
                    1'b0,1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0, 1'b1,1'b0,32'hDEADBEEF,32'h0,32'h0};
        vec[4]  = '{1'b0,4'h0,16'd0,32'h0, 1'b1,4'hF,4'hF,16'd10,16'd11,32'hA0A00010,32'hB0B00011,
                    1'b0,1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h0,32'h0};
        vec[5]  = '{1'b0,4'h0,16'd0,32'h0, 1'b1,4'hF,4'hF,16'd10,16'd11,32'hA0A00010,32'hB0B00011,
                    1'b0,1'b1,4'hF,4'hF,16'd10,16'd11,32'hA0A00010,32'hB0B00011, 1'b0,1'b0,32'hDEADBEEF,32'h0,32'h0};
        vec[6]  = '{1'b0,4'h0,16'd0,32'h0, 1'b1,4'h0,4'h0,16'd10,16'd11,32'h0,32'h0,
                    1'b0,1'b1,4'h0,4'h0,16'd10,16'd11,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h0,32'h0};
        vec[7]  = '{1'b0,4'h0,16'd0,32'h0, 1'b1,4'hF,4'hF,16'd7,16'd7,32'h7777AAAA,32'h7777BBBB,
                    1'b0,1'b1,4'hF,4'h0,16'd7,16'd7,32'h7777AAAA,32'h7777BBBB, 1'b0,1'b1,32'hDEADBEEF,32'hA0A00010,32'hB0B00011};
        vec[8]  = '{1'b0,4'h0,16'd0,32'h0, 1'b1,4'h0,4'h0,16'd7,16'd7,32'h0,32'h0,
                    1'b0,1'b1,4'h0,4'h0,16'd7,16'd7,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'hA0A00010,32'hB0B00011};
        vec[9]  = '{1'b0,4'h0,16'd0,32'h0, 1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0,
                    1'b0,1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0, 1'b0,1'b1,32'hDEADBEEF,32'h7777AAAA,32'h7777AAAA};
        vec[10] = '{1'b1,4'h0,16'd5,32'h0, 1'b1,4'h0,4'h0,16'd10,16'd11,32'h0,32'h0,
                    1'b0,1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h7777AAAA,32'h7777AAAA};
        vec[11] = '{1'b1,4'h0,16'd5,32'h0, 1'b1,4'h0,4'h0,16'd10,16'd11,32'h0,32'h0,
                    1'b0,1'b1,4'h0,4'h0,16'd10,16'd11,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h7777AAAA,32'h7777AAAA};
        vec[12] = '{1'b1,4'h0,16'd5,32'h0, 1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0,
                    1'b0,1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0, 1'b0,1'b1,32'hDEADBEEF,32'hA0A00010,32'hB0B00011};
        vec[13] = '{1'b1,4'h0,16'd5,32'h0, 1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0,
                    1'b1,1'b0,4'h0,4'h0,16'd5,16'd0,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'hA0A00010,32'hB0B00011};
        vec[14] = '{1'b0,4'h0,16'd0,32'h0, 1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0,
                    1'b0,1'b0,4'h0,4'h0,16'd0,16'd0,32'h0,32'h0, 1'b1,1'b0,32'hDEADBEEF,32'hA0A00010,32'hB0B00011};

        set_d(1'b0, 4'h0, 16'd0, 32'h0);
        set_c(1'b0, 4'h0, 4'h0, 16'd0, 16'd0, 32'h0, 32'h0);
        bus_if.err_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 0, 32'({bus_if.dma_gnt, bus_if.cmp_gnt, bus_if.dma_rvalid, bus_if.cmp_rvalid, bus_if.oob_err}), 32'h0);
        chk("rst_wea", 0, 32'({bus_if.wea0, bus_if.wea1}), 32'h0);
        chk("rst_addr", 0, {bus_if.addr0, bus_if.addr1}, 32'h0);
        chk("rst_rdata", 0, bus_if.dma_rdata | bus_if.cmp_rdata_a | bus_if.cmp_rdata_b, 32'h0);
        next_cyc();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            set_d(vec[i].dreq, vec[i].dws, vec[i].dad, vec[i].dwd);
            set_c(vec[i].creq, vec[i].cwa, vec[i].cwb, vec[i].caa, vec[i].cab, vec[i].cda, vec[i].cdb);
            @(negedge clk);
            chk("dma_gnt", i, 32'(bus_if.dma_gnt), 32'(vec[i].e_dg));
            chk("cmp_gnt", i, 32'(bus_if.cmp_gnt), 32'(vec[i].e_cg));
            chk("wea0", i, 32'(bus_if.wea0), 32'(vec[i].e_we0));
            chk("wea1", i, 32'(bus_if.wea1), 32'(vec[i].e_we1));
            chk("addr0", i, 32'(bus_if.addr0), 32'(vec[i].e_a0));
            chk("addr1", i, 32'(bus_if.addr1), 32'(vec[i].e_a1));
            chk("wdata0", i, bus_if.wdata0, vec[i].e_wd0);
            chk("wdata1", i, bus_if.wdata1, vec[i].e_wd1);
            chk("dma_rvalid", i, 32'(bus_if.dma_rvalid), 32'(vec[i].e_drv));
            chk("cmp_rvalid", i, 32'(bus_if.cmp_rvalid), 32'(vec[i].e_crv));
            chk("dma_rdata", i, bus_if.dma_rdata, vec[i].e_drd);
            chk("cmp_rdata_a", i, bus_if.cmp_rdata_a, vec[i].e_crda);
            chk("cmp_rdata_b", i, bus_if.cmp_rdata_b, vec[i].e_crdb);
            next_cyc();
        end

        // Both requesters held: tie goes to compute, then 16-beat bursts alternate without bubbles.
        set_d(1'b1, 4'h0, 16'd5, 32'h0);
        set_c(1'b1, 4'h0, 4'h0, 16'd10, 16'd11, 32'h0, 32'h0);
        prev_dg = 1'b0;
        prev_cg = 1'b0;
        for (int i = 0; i < 36; i++) begin
            exp_cg = (i >= 1 && i <= 16) || (i >= 33);
            exp_dg = (i >= 17 && i <= 32);
            @(negedge clk);
            chk("burst_dma_gnt", i, 32'(bus_if.dma_gnt), 32'(exp_dg));
            chk("burst_cmp_gnt", i, 32'(bus_if.cmp_gnt), 32'(exp_cg));
            chk("burst_dma_rvalid", i, 32'(bus_if.dma_rvalid), 32'(prev_dg));
            chk("burst_cmp_rvalid", i, 32'(bus_if.cmp_rvalid), 32'(prev_cg));
            prev_dg = exp_dg;
            prev_cg = exp_cg;
            next_cyc();
        end
        set_d(1'b0, 4'h0, 16'd0, 32'h0);
        set_c(1'b0, 4'h0, 4'h0, 16'd0, 16'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("burst_tail_cmp_rvalid", 0, 32'(bus_if.cmp_rvalid), 32'h1);
        chk("burst_tail_rdata_a", 0, bus_if.cmp_rdata_a, 32'hA0A00010);
        chk("burst_tail_dma_rdata", 0, bus_if.dma_rdata, 32'hDEADBEEF);
        next_cyc();

`ifdef SRAM_ARB_OOB_CHK_EN
        set_d(1'b1, 4'h0, 16'd480, 32'h0);
        @(negedge clk);
        chk("oob_bubble_gnt", 0, 32'(bus_if.dma_gnt), 32'h0);
        next_cyc();
        @(negedge clk);
        chk("oob_rd_gnt", 0, 32'(bus_if.dma_gnt), 32'h1);
        chk("oob_rd_wea0", 0, 32'(bus_if.wea0), 32'h0);
        chk("oob_rd_addr0", 0, 32'(bus_if.addr0), 32'h0);
        chk("oob_err_pre", 0, 32'(bus_if.oob_err), 32'h0);
        next_cyc();
        set_d(1'b0, 4'h0, 16'd0, 32'h0);
        @(negedge clk);
        chk("oob_rvalid", 0, 32'(bus_if.dma_rvalid), 32'h1);
        chk("oob_rdata", 0, bus_if.dma_rdata, 32'h0);
        chk("oob_err_set", 0, 32'(bus_if.oob_err), 32'h1);
        next_cyc();
        @(negedge clk);
        chk("oob_err_sticky", 0, 32'(bus_if.oob_err), 32'h1);
        chk("oob_rdata_hold", 0, bus_if.dma_rdata, 32'h0);
        next_cyc();
        bus_if.err_clr = 1'b1;
        @(negedge clk);
        chk("oob_err_clr_cycle", 0, 32'(bus_if.oob_err), 32'h1);
        next_cyc();
        bus_if.err_clr = 1'b0;
        @(negedge clk);
        chk("oob_err_cleared", 0, 32'(bus_if.oob_err), 32'h0);
        next_cyc();
        set_d(1'b1, 4'hF, 16'd500, 32'h12345678);
        next_cyc();
        @(negedge clk);
        chk("oob_wr_wea0", 0, 32'(bus_if.wea0), 32'h0);
        chk("oob_wr_addr0", 0, 32'(bus_if.addr0), 32'h0);
        next_cyc();
        bus_if.err_clr = 1'b1;
        @(negedge clk);
        chk("oob_wr_err", 0, 32'(bus_if.oob_err), 32'h1);
        chk("oob_wr_gnt2", 0, 32'(bus_if.dma_gnt), 32'h1);
        next_cyc();
        bus_if.err_clr = 1'b0;
        set_d(1'b0, 4'h0, 16'd0, 32'h0);
        @(negedge clk);
        chk("oob_set_beats_clr", 0, 32'(bus_if.oob_err), 32'h1);
        next_cyc();
        bus_if.err_clr = 1'b1;
        next_cyc();
        bus_if.err_clr = 1'b0;
        @(negedge clk);
        chk("oob_err_final", 0, 32'(bus_if.oob_err), 32'h0);
        next_cyc();
`else
        set_d(1'b1, 4'h0, 16'd480, 32'h0);
        next_cyc();
        @(negedge clk);
        chk("nochk_gnt", 0, 32'(bus_if.dma_gnt), 32'h1);
        chk("nochk_addr0", 0, 32'(bus_if.addr0), 32'd480);
        next_cyc();
        set_d(1'b0, 4'h0, 16'd0, 32'h0);
        @(negedge clk);
        chk("nochk_rvalid", 0, 32'(bus_if.dma_rvalid), 32'h1);
        chk("nochk_oob_err", 0, 32'(bus_if.oob_err), 32'h0);
        next_cyc();
`endif

        // Reset during a read-grant cycle discards the pending tag.
        set_d(1'b1, 4'h0, 16'd5, 32'h0);
        next_cyc();
        @(negedge clk);
        chk("rstrd_gnt", 0, 32'(bus_if.dma_gnt), 32'h1);
        rst_n = 1'b0;
        set_d(1'b0, 4'h0, 16'd0, 32'h0);
        next_cyc();
        @(negedge clk);
        chk("rstrd_rvalid", 0, 32'(bus_if.dma_rvalid), 32'h0);
        chk("rstrd_rdata", 0, bus_if.dma_rdata, 32'h0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
